// File: rtl/led_scan_pkg.sv
// Shared constants for the LED scan controller: state encoding, channel count,
// BCD tens threshold and per-channel slice width.
package led_scan_pkg;

  localparam int NCH     = 4;
  localparam int SLICE_W = 4;

  localparam logic [SLICE_W-1:0] BCD_TENS = 4'd10;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_LOAD = 2'd1;
  localparam state_t S_SHOW = 2'd2;
  localparam state_t S_NEXT = 2'd3;

endpackage

// File: rtl/led_bcd4.sv
// Combinational 4-bit binary to two-digit BCD converter (values 0..15 only,
// so the tens digit is at most 1).
module led_bcd4
  import led_scan_pkg::*;
(
  input  logic [SLICE_W-1:0] bin,
  output logic [7:0]         bcd
);

  always_comb begin
    if (bin >= BCD_TENS) begin
      bcd = {4'd1, bin - BCD_TENS};
    end else begin
      bcd = {4'd0, bin};
    end
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// Round-robin LED scan controller feeding a two-digit LED driver.
// Optional macro LED_SCAN_BLINK_EN blinks 'on' during the last quarter of each dwell.
module led_scan_ctrl #(
  parameter int NCH   = led_scan_pkg::NCH,
  parameter int DWELL = 1000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NCH-1:0]                       req,
  input  logic [NCH*led_scan_pkg::SLICE_W-1:0] din,
  output logic [NCH-1:0]                       grant,
  output logic [7:0]                           out,
  output logic                                 set,
  output logic                                 en,
  output logic                                 on,
  output logic                                 busy
);

  import led_scan_pkg::*;

  localparam int          PTR_W    = $clog2(NCH);
  localparam logic [15:0] CNT_LAST = 16'(DWELL - 1);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   sel_q, sel_d;
  logic [PTR_W-1:0]   winner, idx;
  logic [NCH-1:0]     grant_q, grant_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [7:0]         out_q, out_d;
  logic               set_q, set_d;
  logic [SLICE_W-1:0] slice;
  logic [7:0]         bcd;

  // Walk the offsets from farthest to nearest so the requester closest after ptr wins.
  always_comb begin
    winner = ptr_q;
    idx    = ptr_q;
    for (int i = NCH; i >= 1; i--) begin
      idx = ptr_q + PTR_W'(i);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

  assign slice = din[int'(sel_q)*SLICE_W +: SLICE_W];

  led_bcd4 u_bcd (
    .bin (slice),
    .bcd (bcd)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = '0;
    cnt_d   = cnt_q;
    out_d   = out_q;
    set_d   = 1'b0;
    case (state_q)
      S_IDLE, S_NEXT: begin
        if (|req) begin
          state_d = S_LOAD;
          sel_d   = winner;
          grant_d = NCH'(1) << winner;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        ptr_d   = sel_q;
        out_d   = bcd;
        set_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ptr resets to the last channel so channel 0 is the first one served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_W'(NCH - 1);
      sel_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      out_q   <= 8'h00;
      set_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      set_q   <= set_d;
    end
  end

  assign grant = grant_q;
  assign out   = out_q;
  assign set   = set_q;
  assign en    = (state_q == S_SHOW);
  assign busy  = (state_q != S_IDLE);

`ifdef LED_SCAN_BLINK_EN
  localparam logic [15:0] BLINK_START = 16'(DWELL - DWELL / 4);
  assign on = en & ((cnt_q >= BLINK_START) ? ~cnt_q[1] : 1'b1);
`else
  assign on = en;
`endif

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4, number of requesting channels (fixed 4 in this revision).
REQ-002 SHALL have parameter DWELL, default 1000, number of SHOW cycles per channel (legal 16..65535).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  4  per-channel display request, level.
REQ-006 SHALL have port din  input  16  channel values, din[4k+3:4k] = channel k, binary 0..15.
REQ-007 SHALL have port grant  output  1-hot 4  channel accepted, one-cycle pulse.
REQ-008 SHALL have port out  output  8  BCD to LED2 in: [7:4] tens, [3:0] units.
REQ-009 SHALL have port set  output  1  one-cycle load strobe to LED2.
REQ-010 SHALL have port en  output  1  LED2 enable.
REQ-011 SHALL have port on  output  1  LED2 lit.
REQ-012 SHALL have port busy  output  1  high when the state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SHOW and NEXT.
REQ-014 IDLE SHALL go to LOAD on the next edge when any req is high; otherwise it SHALL stay in IDLE.
REQ-015 On entry to LOAD, the granted channel SHALL be the first requester searching round-robin from ptr+1 (mod 4).
REQ-016 LOAD SHALL last 1 cycle: grant[k]=1, capture din slice k, ptr<=k, then go to SHOW.
REQ-017 BCD conversion: v<10 -> out={4'd0,v}; v>=10 -> out={4'd1,v-10}.
REQ-018 out and set SHALL be registered; set=1 exactly in the first SHOW cycle, coincident with the new out value.
REQ-019 Latency: req rising in IDLE at cycle 0 -> grant at cycle 1 -> out/set at cycle 2.
REQ-020 SHOW SHALL hold out, en=1, on=1, with counter cnt running 0..DWELL-1; at cnt=DWELL-1 it SHALL go to NEXT.
REQ-021 Dropping req during SHOW SHALL NOT shorten the dwell.
REQ-022 NEXT SHALL last 1 cycle: any req -> LOAD (round-robin resumes after ptr); none -> IDLE.
REQ-023 In IDLE, en=0 and on=0, and out SHALL hold its last value.
REQ-024 Single persistent requester: the same channel SHALL be re-served every DWELL+2 cycles.
REQ-025 All four requesting: service order SHALL be ptr+1, ptr+2, ... with no starvation.
REQ-026 grant SHALL be zero outside LOAD.

Reset
REQ-027 rst low SHALL asynchronously force: state=IDLE, ptr=3 (so channel 0 wins first), cnt=0, out=8'h00, grant=0, set=0, en=0, on=0, busy=0.
REQ-028 Reset asserted mid-SHOW SHALL abort the dwell, with no further set until a new LOAD.

Configuration
REQ-029 Macro LED_SCAN_BLINK_EN defined: in SHOW with cnt >= DWELL-DWELL/4, on SHALL equal ~cnt[1] (pre-switch blink warning); everywhere else on SHALL follow REQ-020/REQ-023.
REQ-030 Macro LED_SCAN_BLINK_EN undefined: on SHALL equal en at all times, with no blink logic synthesized.

Structure
REQ-031 Package led_scan_pkg SHALL hold the state enum, NCH, BCD tens threshold 10, and the channel-slice width 4.
REQ-032 Sub-module led_bcd4 SHALL be a combinational 4-bit binary -> 8-bit BCD converter used in LOAD; the FSM, arbiter, counter and blink logic SHALL stay in led_scan_ctrl.

Verification (DWELL=16)
REQ-033 Reset, then req=0001 and din[3:0]=4'd13 -> grant=0001 at cycle 1; out=8'h13 and set=1 at cycle 2; en=on=1 for 16 cycles.
REQ-034 req=1111 held, din={4'd15,4'd9,4'd10,4'd2} -> grants 0001,0010,0100,1000,0001 spaced 18 cycles; outs 02,10,09,15.
REQ-035 req=0100 pulsed for 1 cycle from IDLE -> full 16-cycle SHOW, then NEXT -> IDLE, en=0, out holds 8'h(value).
REQ-036 rst pulsed low at cnt=7 in SHOW -> all outputs zero immediately; after release with req=0010, channel 1 served first.
REQ-037 LED_SCAN_BLINK_EN defined, one requester -> on=1,1,0,0 across cnt 12..15, and on=1 for cnt 0..11.
REQ-038 req switches 0001->0010 during SHOW of channel 0 -> channel 0 finishes its 16 cycles, then grant=0010 one cycle after NEXT.
